// File: rtl/rca_multicycle_adder_if.sv
// Operand/result handshake bundle for the multi-cycle ripple-carry adder.
// The adder uses the slave view; the producer/consumer side uses the master view.
interface rca_multicycle_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, op_sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, op_sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/rca_multicycle_adder.sv
// Multi-cycle ripple-carry adder/subtractor: one CHUNK-wide slice per clock with a
// registered carry, valid/ready on both sides. WIDTH must be a multiple of CHUNK.
module rca_multicycle_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  rca_multicycle_adder_if.slave bus
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned SW     = CHUNK + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   w_a_nxt;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   w_b_nxt;
  logic               r_carry;
  logic               w_carry_nxt;
  logic [WIDTH-1:0]   r_sum;
  logic [WIDTH-1:0]   w_sum_nxt;
  logic               r_cout;
  logic               w_cout_nxt;
  logic               r_ovf;
  logic               w_ovf_nxt;
  logic               r_out_valid;
  logic               w_out_valid_nxt;

  logic [CHUNK-1:0]   w_sa;
  logic [CHUNK-1:0]   w_sb;
  logic [SW-1:0]      w_slice;
  logic               w_last;
  logic               w_slice_ovf;
  logic               w_in_ready_c;

  assign w_in_ready_c = (r_state == S_IDLE) && !rst;

  // Select the operand slice addressed by the chunk counter.
  always_comb begin
    w_sa = '0;
    w_sb = '0;
    for (int k = 0; k < int'(NCHUNK); k++) begin
      if (r_cnt == CNT_W'(k)) begin
        w_sa = r_a[k*CHUNK +: CHUNK];
        w_sb = r_b[k*CHUNK +: CHUNK];
      end
    end
  end

  assign w_slice = {1'b0, w_sa} + {1'b0, w_sb} + SW'(r_carry);
  assign w_last  = (r_cnt == CNT_W'(NCHUNK - 1));

  // Carry into the slice MSB is recovered as a^b^s at that bit position.
  assign w_slice_ovf = w_sa[CHUNK-1] ^ w_sb[CHUNK-1] ^ w_slice[CHUNK-1] ^ w_slice[CHUNK];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_a_nxt         = r_a;
    w_b_nxt         = r_b;
    w_carry_nxt     = r_carry;
    w_sum_nxt       = r_sum;
    w_cout_nxt      = r_cout;
    w_ovf_nxt       = r_ovf;
    w_out_valid_nxt = r_out_valid;

    case (r_state)
      S_IDLE: begin
        if (bus.in_valid && w_in_ready_c) begin
          w_a_nxt     = bus.a;
          w_b_nxt     = bus.op_sub ? ~bus.b : bus.b;
          w_carry_nxt = bus.op_sub ? 1'b1 : bus.cin;
          w_cnt_nxt   = '0;
          w_state_nxt = S_RUN;
        end
      end

      S_RUN: begin
        for (int k = 0; k < int'(NCHUNK); k++) begin
          if (r_cnt == CNT_W'(k)) begin
            w_sum_nxt[k*CHUNK +: CHUNK] = w_slice[CHUNK-1:0];
          end
        end
        w_carry_nxt = w_slice[CHUNK];
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        if (w_last) begin
          w_cout_nxt      = w_slice[CHUNK];
          w_ovf_nxt       = w_slice_ovf;
          w_out_valid_nxt = 1'b1;
          w_cnt_nxt       = '0;
          w_state_nxt     = S_DONE;
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end

      default: begin
        w_out_valid_nxt = 1'b0;
        w_state_nxt     = S_IDLE;
      end
    endcase
  end

  // Datapath registers; reset discards any partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_carry     <= w_carry_nxt;
      r_sum       <= w_sum_nxt;
      r_cout      <= w_cout_nxt;
      r_ovf       <= w_ovf_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  assign bus.in_ready  = w_in_ready_c;
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;

endmodule
